uart_key_lock: RTL and testbench
================================

# uart_key_lock

Parametrised serial key lock: an 8N1 UART receiver with a configurable bit period, feeding a sliding window of the last `KEY_BYTES` received bytes. The window is compared against a compile-time key. Compared with the previous generation, it adds an input synchroniser, false-start rejection, stop-bit framing checks, window-fill tracking and a registered unlock output. It sits at board top level between the UART pin and the status LEDs.

## Interface
Parameters:
- `CLKS_PER_BAUD`, 87: clock cycles per bit (10 MHz / 115200); minimum 4.
- `KEY_BYTES`, 8: key length in bytes; minimum 1.
- `KEY`, 0: `8*KEY_BYTES`-bit key. `KEY[7:0]` is the last byte sent; `KEY[8*KEY_BYTES-1 -: 8]` is the first.

Ports:
- `clk_10` in, 1: the single clock.
- `rst_n` in, 1: asynchronous, active-low reset.
- `uart` in, 1: asynchronous serial input; idles high.
- `rx_byte` out, 8: last correctly framed byte.
- `rx_valid` out, 1: one-cycle pulse when `rx_byte` updates.
- `frame_err` out, 1: one-cycle pulse on a stop bit sampled low.
- `open` out, 1: the key matches.
- `led_red` out, 1: equals `open`.
- `led_green` out, 1: equals `!open`.

## Operation
- `uart` passes through a 2-flop synchroniser (reset value 1); the receiver sees only the synchronised signal, `rxs`.
- States: IDLE, START, DATA, STOP.
  - IDLE: when `rxs`==0, go to START and load the counter with `CLKS_PER_BAUD/2 - 1`.
  - START: count down. At 0, sample `rxs`.
    - If 1 (false start), return to IDLE.
    - If 0, go to DATA, set bit index 0 and load `CLKS_PER_BAUD-1`.
  - DATA: at counter 0, sample `rxs` into `shift[bit]`, LSB first.
    - Reload `CLKS_PER_BAUD-1` at each sample.
    - After bit 7, go to STOP.
  - STOP: at counter 0, sample `rxs`, then go to IDLE.
    - If 1: `rx_byte` takes the shifted byte and `rx_valid` pulses.
    - If 0: `frame_err` pulses.
- Every sample lands mid-bit, 1.5 bit periods after the falling edge for bit 0.
- Window: a `8*KEY_BYTES`-bit shift register.
  - On `rx_valid`: window ← {window[8*KEY_BYTES-9:0], rx_byte}, and `fill` increments, saturating at `KEY_BYTES`.
  - On `frame_err`: window and `fill` clear to 0.
- `open` is registered. It updates on the cycle after `rx_valid` or `frame_err` and holds otherwise.
  - Next value = (`fill`==`KEY_BYTES`) && (window==`KEY`).
  - A frame error forces 0.
- Sliding match: any byte stream whose last `KEY_BYTES` framed bytes equal the key opens the lock. Trailing garbage closes it again.

## Timing
- Reset: all registers clear asynchronously.
  - `rx_byte`=0, `rx_valid`=0, `frame_err`=0, `open`=0, `led_red`=0, `led_green`=1.
  - State is IDLE, `fill`=0, synchroniser outputs are 1.
- Reset asserted mid-frame aborts the frame. After release, the receiver waits in IDLE for a new falling edge, so a line still low right after release starts a frame.
- Latency:
  - Synchroniser: 2 cycles.
  - Start edge to `rx_valid`: 2 + `CLKS_PER_BAUD/2` + 9·`CLKS_PER_BAUD` cycles, ±1.
  - `open`: 1 cycle after `rx_valid`.
- Back-to-back frames: the receiver re-enters IDLE mid-stop-bit, so the next start bit can be accepted with no idle gap.
- A line held low: the first frame gives `frame_err`. The receiver then restarts immediately in START and yields a `frame_err` for every frame period until the line goes high.
- `rx_valid` and `frame_err` are never high in the same cycle.
- The counter width is `$clog2(CLKS_PER_BAUD)`. It decrements only while nonzero, with no wrap.

## Structure
- Shared package `uart_pkg`:
  - state enumeration (IDLE/START/DATA/STOP);
  - default `CLKS_PER_BAUD` constant.
- One sub-module, `uart_rx`: synchroniser, FSM, counter and byte assembly. Its outputs are `rx_byte`, `rx_valid` and `frame_err`.
- `uart_key_lock` contains the window, `fill` and the comparator.

## Test plan
- Reset release with the line idle: `open`=0, `led_green`=1, no pulses for 10 frame times.
- KEY_BYTES=2, KEY=16'h4142; send 0x41, 0x42 → `rx_valid` twice with `rx_byte`=0x41 then 0x42. `open`=1 one cycle after the second `rx_valid`.
- Same configuration; send 0x00, 0x41, 0x42, then 0x43 → `open` rises after 0x42 and falls one cycle after the 0x43 `rx_valid`.
- Low glitch of `CLKS_PER_BAUD/4` cycles on idle line → no `rx_valid`, no `frame_err`, state back to IDLE.
- Send 0x41, then a frame with a low stop bit, then 0x42 → one `frame_err`; `fill` reset, so `open` stays 0.
- Assert `rst_n` during bit 4 of a frame, release, send 0x41, 0x42 → clean reception and `open`=1. Also run with CLKS_PER_BAUD=16 and KEY_BYTES=1.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART receive path.
package uart_pkg;

    localparam int unsigned CLKS_PER_BAUD_DEFAULT = 87;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: input synchroniser, mid-bit sampling FSM, false-start
// rejection and stop-bit framing check.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BAUD = CLKS_PER_BAUD_DEFAULT
) (
    input  logic       clk_10,
    input  logic       rst_n,
    input  logic       uart,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       frame_err
);

    localparam int unsigned     CNT_W     = $clog2(CLKS_PER_BAUD);
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BAUD / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLKS_PER_BAUD - 1);

    logic             sync1;
    logic             rxs;
    rx_state_t        state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [2:0]       bit_idx, bit_d;
    logic [7:0]       shift, shift_d;
    logic [7:0]       byte_d;
    logic             valid_d;
    logic             ferr_d;

    // Two-flop synchroniser; idles high like the line itself
    always_ff @(posedge clk_10 or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            rxs   <= 1'b1;
        end else begin
            sync1 <= uart;
            rxs   <= sync1;
        end
    end

    always_ff @(posedge clk_10 or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            rx_byte   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            bit_idx   <= bit_d;
            shift     <= shift_d;
            rx_byte   <= byte_d;
            rx_valid  <= valid_d;
            frame_err <= ferr_d;
        end
    end

    // Counter only runs down to zero; each state acts on the zero cycle
    always_comb begin
        state_d = state;
        cnt_d   = (cnt != '0) ? cnt - CNT_W'(1) : cnt;
        bit_d   = bit_idx;
        shift_d = shift;
        byte_d  = rx_byte;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        case (state)
            IDLE: begin
                if (!rxs) begin
                    state_d = START;
                    cnt_d   = HALF_LOAD;
                end
            end
            START: begin
                if (cnt == '0) begin
                    if (rxs) begin
                        state_d = IDLE;
                    end else begin
                        state_d = DATA;
                        bit_d   = 3'd0;
                        cnt_d   = FULL_LOAD;
                    end
                end
            end
            DATA: begin
                if (cnt == '0) begin
                    shift_d[bit_idx] = rxs;
                    cnt_d            = FULL_LOAD;
                    if (bit_idx == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_d = bit_idx + 3'd1;
                    end
                end
            end
            STOP: begin
                if (cnt == '0) begin
                    state_d = IDLE;
                    if (rxs) begin
                        byte_d  = shift;
                        valid_d = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: rtl/uart_key_lock.sv
// Serial key lock: sliding window of the last KEY_BYTES framed bytes compared
// against a compile-time key, with registered open and LED outputs.
module uart_key_lock
    import uart_pkg::*;
#(
    parameter int unsigned               CLKS_PER_BAUD = CLKS_PER_BAUD_DEFAULT,
    parameter int unsigned               KEY_BYTES     = 8,
    parameter logic [8*KEY_BYTES-1:0]    KEY           = '0
) (
    input  logic       clk_10,
    input  logic       rst_n,
    input  logic       uart,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       open,
    output logic       led_red,
    output logic       led_green
);

    localparam int unsigned      WIN_W     = 8 * KEY_BYTES;
    localparam int unsigned      FILL_W    = $clog2(KEY_BYTES + 1);
    localparam logic [FILL_W-1:0] FULL_FILL = FILL_W'(KEY_BYTES);

    logic [WIN_W-1:0]  window, window_d, shifted;
    logic [FILL_W-1:0] fill, fill_d;
    logic              open_d;

    uart_rx #(
        .CLKS_PER_BAUD(CLKS_PER_BAUD)
    ) u_rx (
        .clk_10   (clk_10),
        .rst_n    (rst_n),
        .uart     (uart),
        .rx_byte  (rx_byte),
        .rx_valid (rx_valid),
        .frame_err(frame_err)
    );

    // A one-byte window is simply replaced rather than shifted
    generate
        if (KEY_BYTES == 1) begin : g_single
            assign shifted = rx_byte;
        end else begin : g_multi
            assign shifted = {window[WIN_W-9:0], rx_byte};
        end
    endgenerate

    // Match is judged on the post-update window so open follows rx_valid by one cycle
    always_comb begin
        window_d = window;
        fill_d   = fill;
        open_d   = open;
        if (frame_err) begin
            window_d = '0;
            fill_d   = '0;
            open_d   = 1'b0;
        end else if (rx_valid) begin
            window_d = shifted;
            if (fill != FULL_FILL) begin
                fill_d = fill + FILL_W'(1);
            end
            open_d = (fill_d == FULL_FILL) && (window_d == KEY);
        end
    end

    always_ff @(posedge clk_10 or negedge rst_n) begin
        if (!rst_n) begin
            window    <= '0;
            fill      <= '0;
            open      <= 1'b0;
            led_red   <= 1'b0;
            led_green <= 1'b1;
        end else begin
            window    <= window_d;
            fill      <= fill_d;
            open      <= open_d;
            led_red   <= open_d;
            led_green <= !open_d;
        end
    end

endmodule

// File: tb/tb_uart_key_lock.sv
// Bench for uart_key_lock: two configurations driven by directed serial frames,
// checked every cycle against a byte-history model plus literal expectations.
module tb_uart_key_lock;

    localparam int CPB0 = 87;
    localparam int CPB1 = 16;

    typedef struct {
        int         d;
        bit         ok;
        logic [7:0] b;
        longint     lo;
        longint     hi;
    } exp_t;

    logic       clk_10 = 1'b0;
    logic [1:0] rst_n;
    logic [1:0] uart;
    logic [7:0] rx_byte [2];
    logic [1:0] rx_valid, frame_err, open_o, led_red, led_green;

    int     checks   = 0;
    int     failures = 0;
    longint cyc      = 0;

    exp_t       exp_q[$];
    logic [7:0] hist  [2][8];
    int         hcnt  [2];
    logic [7:0] key_b [2][8];
    logic [7:0] mbyte [2];
    bit         mopen [2];

    uart_key_lock #(.CLKS_PER_BAUD(CPB0), .KEY_BYTES(2), .KEY(16'h4142)) dut0 (
        .clk_10(clk_10), .rst_n(rst_n[0]), .uart(uart[0]),
        .rx_byte(rx_byte[0]), .rx_valid(rx_valid[0]), .frame_err(frame_err[0]),
        .open(open_o[0]), .led_red(led_red[0]), .led_green(led_green[0]));

    uart_key_lock #(.CLKS_PER_BAUD(CPB1), .KEY_BYTES(1), .KEY(8'h5A)) dut1 (
        .clk_10(clk_10), .rst_n(rst_n[1]), .uart(uart[1]),
        .rx_byte(rx_byte[1]), .rx_valid(rx_valid[1]), .frame_err(frame_err[1]),
        .open(open_o[1]), .led_red(led_red[1]), .led_green(led_green[1]));

    always #5 clk_10 = ~clk_10;
    always @(posedge clk_10) cyc <= cyc + 1;

    function automatic int cpb_of(input int d);
        return (d == 0) ? CPB0 : CPB1;
    endfunction

    function automatic int kb_of(input int d);
        return (d == 0) ? 2 : 1;
    endfunction

    // Lock is open when the last kb bytes received equal the key bytes in order
    function automatic bit model_match(input int d);
        if (hcnt[d] != kb_of(d)) return 1'b0;
        for (int i = 0; i < kb_of(d); i++)
            if (hist[d][i] != key_b[d][i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_push(input int d, input logic [7:0] b);
        if (hcnt[d] == kb_of(d)) begin
            for (int i = 0; i < kb_of(d) - 1; i++) hist[d][i] = hist[d][i+1];
            hist[d][kb_of(d)-1] = b;
        end else begin
            hist[d][hcnt[d]] = b;
            hcnt[d]++;
        end
    endtask

    task automatic chk(input string name, input longint act, input longint expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk_10);
    endtask

    // One 8N1 frame; a bad frame holds the stop bit low past its sample point
    task automatic send_frame(input int d, input logic [7:0] b, input bit ok);
        int   c;
        int   lat;
        exp_t e;
        c    = cpb_of(d);
        lat  = 2 + c / 2 + 9 * c;
        e.d  = d;
        e.ok = ok;
        e.b  = b;
        e.lo = cyc + lat - 1;
        e.hi = cyc + lat + 3;
        exp_q.push_back(e);
        uart[d] = 1'b0;
        wait_clk(c);
        for (int i = 0; i < 8; i++) begin
            uart[d] = b[i];
            wait_clk(c);
        end
        if (ok) begin
            uart[d] = 1'b1;
            wait_clk(c);
        end else begin
            uart[d] = 1'b0;
            wait_clk(c / 2 + 4);
            uart[d] = 1'b1;
            wait_clk(c - c / 2 - 4 + 2 * c);
        end
    endtask

    task automatic glitch(input int d);
        uart[d] = 1'b0;
        wait_clk(cpb_of(d) / 4);
        uart[d] = 1'b1;
        wait_clk(3 * 10 * cpb_of(d));
    endtask

    // Start a 0xFF frame, pull reset during data bit 4, then release on an idle line
    task automatic reset_mid_frame(input int d);
        uart[d] = 1'b0;
        wait_clk(cpb_of(d));
        uart[d] = 1'b1;
        wait_clk(4 * cpb_of(d) + cpb_of(d) / 2);
        rst_n[d] = 1'b0;
        wait_clk(3);
        chk("reset_open", open_o[d], 0);
        chk("reset_led_green", led_green[d], 1);
        chk("reset_rx_byte", rx_byte[d], 0);
        rst_n[d] = 1'b1;
        wait_clk(2 * 10 * cpb_of(d));
    endtask

    always @(posedge clk_10) begin
        exp_t e;
        bit   nopen;
        #1;
        for (int d = 0; d < 2; d++) begin
            nopen = mopen[d];
            if (!rst_n[d]) begin
                hcnt[d]  = 0;
                mbyte[d] = 8'h00;
                mopen[d] = 1'b0;
                nopen    = 1'b0;
                for (int i = exp_q.size() - 1; i >= 0; i--)
                    if (exp_q[i].d == d) exp_q.delete(i);
            end else begin
                if (exp_q.size() > 0 && exp_q[0].d == d && cyc > exp_q[0].hi) begin
                    chk("pulse_timeout", 0, 1);
                    void'(exp_q.pop_front());
                end
                chk("valid_err_overlap", rx_valid[d] & frame_err[d], 0);
                if (rx_valid[d] | frame_err[d]) begin
                    if (exp_q.size() == 0 || exp_q[0].d != d) begin
                        chk("unexpected_pulse", {rx_valid[d], frame_err[d]}, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("pulse_kind_valid", rx_valid[d], e.ok);
                        chk("pulse_in_window", (cyc >= e.lo) && (cyc <= e.hi), 1);
                        if (e.ok) begin
                            mbyte[d] = e.b;
                            model_push(d, e.b);
                        end else begin
                            hcnt[d] = 0;
                        end
                        nopen = model_match(d);
                    end
                end
            end
            chk("rx_byte", rx_byte[d], mbyte[d]);
            chk("open", open_o[d], mopen[d]);
            chk("led_red", led_red[d], mopen[d]);
            chk("led_green", led_green[d], !mopen[d]);
            mopen[d] = nopen;
        end
    end

    initial begin
        rst_n = 2'b00;
        uart  = 2'b11;
        hcnt[0] = 0;
        hcnt[1] = 0;
        mbyte[0] = 8'h00;
        mbyte[1] = 8'h00;
        mopen[0] = 1'b0;
        mopen[1] = 1'b0;
        key_b[0][0] = 8'h41;
        key_b[0][1] = 8'h42;
        key_b[1][0] = 8'h5A;
        wait_clk(5);
        rst_n = 2'b11;

        // Idle line after reset: lock closed, no pulses
        wait_clk(10 * 10 * CPB0);
        chk("idle_open", open_o[0], 0);
        chk("idle_led_green", led_green[0], 1);

        send_frame(0, 8'h41, 1'b1);
        chk("t2_byte1", rx_byte[0], 8'h41);
        chk("t2_open_after_first", open_o[0], 0);
        send_frame(0, 8'h42, 1'b1);
        chk("t2_byte2", rx_byte[0], 8'h42);
        chk("t2_open", open_o[0], 1);
        chk("t2_model_window", {hist[0][0], hist[0][1]}, 16'h4142);

        // Sliding match, then trailing garbage closes
        send_frame(0, 8'h00, 1'b1);
        chk("t3_open_after_00", open_o[0], 0);
        send_frame(0, 8'h41, 1'b1);
        send_frame(0, 8'h42, 1'b1);
        chk("t3_open_after_42", open_o[0], 1);
        send_frame(0, 8'h43, 1'b1);
        chk("t3_open_after_43", open_o[0], 0);
        chk("t3_model_closed", mopen[0], 0);

        // Short low glitch is a false start; receiver still in step afterwards
        glitch(0);
        chk("t4_open_after_glitch", open_o[0], 0);
        send_frame(0, 8'h41, 1'b1);
        send_frame(0, 8'h42, 1'b1);
        chk("t4_open_after_key", open_o[0], 1);

        // Framing error clears the window
        send_frame(0, 8'h41, 1'b1);
        send_frame(0, 8'h55, 1'b0);
        chk("t5_open_after_err", open_o[0], 0);
        send_frame(0, 8'h42, 1'b1);
        chk("t5_open_after_42", open_o[0], 0);
        chk("t5_model_fill", hcnt[0], 1);

        // Reset mid-frame after the lock was open
        send_frame(0, 8'h41, 1'b1);
        send_frame(0, 8'h42, 1'b1);
        chk("t6_open_before_reset", open_o[0], 1);
        reset_mid_frame(0);
        send_frame(0, 8'h41, 1'b1);
        send_frame(0, 8'h42, 1'b1);
        chk("t6_open_after_reset", open_o[0], 1);

        // Short bit period, single-byte key
        send_frame(1, 8'h5A, 1'b1);
        chk("k1_open_5a", open_o[1], 1);
        chk("k1_byte_5a", rx_byte[1], 8'h5A);
        send_frame(1, 8'h5B, 1'b1);
        chk("k1_open_5b", open_o[1], 0);
        send_frame(1, 8'h5A, 1'b1);
        chk("k1_open_5a_again", open_o[1], 1);
        send_frame(1, 8'h33, 1'b0);
        chk("k1_open_after_err", open_o[1], 0);
        glitch(1);
        send_frame(1, 8'h5A, 1'b1);
        chk("k1_open_after_glitch", open_o[1], 1);
        reset_mid_frame(1);
        send_frame(1, 8'h5A, 1'b1);
        chk("k1_open_after_reset", open_o[1], 1);
        chk("k1_dut0_untouched", open_o[0], 1);

        wait_clk(2 * 10 * CPB0);
        chk("pending_expectations", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
